// File: rtl/irq_controller_pkg.sv
// Shared interrupt-controller definitions: FSM encoding, control-flow opcode
// constants and the safe-to-redirect opcode test used by the PC logic as well.
package irq_controller_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

  localparam logic [11:0] OPC_RETIRQ = 12'b0011_1001_1000;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;

  // An interrupt may only replace the next PC of a non-control-flow instruction.
  function automatic logic is_safe_opcode(input logic [11:0] opcode);
    logic ctrl_flow;
    ctrl_flow = (opcode[6:0] == OPC_BRANCH) || (opcode[6:0] == OPC_JAL) ||
                (opcode[6:0] == OPC_JALR);
    return !ctrl_flow && (opcode != OPC_RETIRQ);
  endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// Two-flop synchronizer for one asynchronous request line plus rising-edge
// detection on the synchronized value.
module irq_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic rise
);

  logic       sync1;
  logic       sync2;
  logic       prev;
  logic [2:0] settle;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      prev   <= 1'b0;
      settle <= '0;
    end else begin
      sync1  <= line;
      sync2  <= sync1;
      prev   <= sync2;
      settle <= {settle[1:0], 1'b1};
    end
  end

  // Edges are ignored until prev holds a post-reset sample, so a line that is
  // already high when reset releases never looks like a new request.
  assign rise = sync2 & ~prev & settle[2];

endmodule

// File: rtl/irq_controller.sv
// Single-level interrupt controller: latches request edges, arms the lowest
// enabled pending line and redirects the PC on the next safe retirement.
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int unsigned N_IRQ        = 8,
  parameter logic [31:0] VECTOR_BASE  = 32'h0000_0100,
  parameter int unsigned VECTOR_SHIFT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_lines,
  input  logic [N_IRQ-1:0] irq_mask,
  input  logic             enable_pc,
  input  logic [31:0]      pc,
  input  logic [11:0]      opcode,
  output logic             irr,
  output logic [31:0]      irr_dest,
  output logic [31:0]      irr_ret,
  output logic [4:0]       irq_id,
  output logic             in_service
);

  irq_state_t       state;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] req;
  logic [N_IRQ-1:0] id_onehot;
  logic [N_IRQ-1:0] clr_vec;
  logic [4:0]       lowest_id;
  logic             id_enabled;
  logic             accept;

  irq_edge_sync u_sync [N_IRQ-1:0] (
    .clk  (clk),
    .rst  (rst),
    .line (irq_lines),
    .rise (rise)
  );

  assign req        = pending & irq_mask;
  assign id_onehot  = N_IRQ'(1) << irq_id;
  assign id_enabled = |(irq_mask & id_onehot);

  always_comb begin
    lowest_id = '0;
    for (int unsigned i = N_IRQ; i > 0; i--) begin
      if (req[i-1]) lowest_id = 5'(i - 1);
    end
  end

  // Masking the armed line mid-wait suppresses the redirect immediately.
  assign irr      = (state == ARMED) && id_enabled && is_safe_opcode(opcode);
  assign accept   = irr && enable_pc;
  assign clr_vec  = accept ? id_onehot : '0;
  assign irr_dest = VECTOR_BASE + (32'(irq_id) << VECTOR_SHIFT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      pending    <= '0;
      irr_ret    <= '0;
      irq_id     <= '0;
      in_service <= 1'b0;
    end else begin
      // A fresh edge in the clearing cycle keeps the line pending.
      pending <= (pending & ~clr_vec) | rise;
      case (state)
        IDLE: begin
          if (|req) begin
            state  <= ARMED;
            irq_id <= lowest_id;
          end
        end
        ARMED: begin
          if (!id_enabled) begin
            state <= IDLE;
          end else if (accept) begin
            state      <= SERVICE;
            irr_ret    <= pc + 32'd4;
            in_service <= 1'b1;
          end
        end
        SERVICE: begin
          if (enable_pc && (opcode == OPC_RETIRQ)) begin
            state      <= IDLE;
            in_service <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_irq_controller;

  localparam logic [11:0] ADD    = 12'h033;
  localparam logic [11:0] JAL    = 12'h06F;
  localparam logic [11:0] BEQ    = 12'h063;
  localparam logic [11:0] JALR   = 12'h067;
  localparam logic [11:0] RETIRQ = 12'h398;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  lines;
  logic [7:0]  mask;
  logic        enable_pc;
  logic [31:0] pc;
  logic [11:0] opcode;
  logic        irr;
  logic [31:0] irr_dest;
  logic [31:0] irr_ret;
  logic [4:0]  irq_id;
  logic        in_service;

  int checks = 0;
  int errors = 0;

  irq_controller #(
    .N_IRQ        (8),
    .VECTOR_BASE  (32'h0000_0100),
    .VECTOR_SHIFT (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_lines  (lines),
    .irq_mask   (mask),
    .enable_pc  (enable_pc),
    .pc         (pc),
    .opcode     (opcode),
    .irr        (irr),
    .irr_dest   (irr_dest),
    .irr_ret    (irr_ret),
    .irq_id     (irq_id),
    .in_service (in_service)
  );

  always #5 clk = ~clk;

  // Reference model: state 0 idle, 1 waiting for a safe retire, 2 in handler.
  int          m_state;
  int          m_id;
  int          m_nsamp;
  logic [7:0]  m_pend, m_last, m_d1, m_d2, m_rise, m_set, m_clr;
  logic [31:0] m_ret;
  logic        m_insvc;

  function automatic bit ref_safe(input logic [11:0] op);
    case (op[6:0])
      7'h63, 7'h6F, 7'h67: return 1'b0;
      default:             return op != 12'h398;
    endcase
  endfunction

  function automatic bit ref_irr();
    return (m_state == 1) && ref_safe(opcode) && mask[m_id];
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_state = 0; m_id = 0; m_nsamp = 0; m_pend = '0; m_last = '0;
      m_d1 = '0; m_d2 = '0; m_ret = '0; m_insvc = 1'b0;
    end else begin
      // A rise counts only between two post-reset samples; it reaches the
      // pending set two edges after the sample that shows it.
      m_rise = (m_nsamp >= 1) ? (lines & ~m_last) : 8'h00;
      m_last = lines;
      m_nsamp++;
      m_set = m_d2;
      m_d2  = m_d1;
      m_d1  = m_rise;
      m_clr = '0;
      case (m_state)
        0: if ((m_pend & mask) != 0) begin
             m_state = 1;
             for (int i = 7; i >= 0; i--) if (m_pend[i] && mask[i]) m_id = i;
           end
        1: if (!mask[m_id]) m_state = 0;
           else if (ref_safe(opcode) && enable_pc) begin
             m_state = 2; m_ret = pc + 32'd4; m_insvc = 1'b1; m_clr[m_id] = 1'b1;
           end
        default: if (enable_pc && opcode == 12'h398) begin
             m_state = 0; m_insvc = 1'b0;
           end
      endcase
      m_pend = (m_pend & ~m_clr) | m_set;
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cycles(input int n);
    repeat (n) cyc();
  endtask

  task automatic do_reset();
    rst = 1'b0; lines = '0; mask = 8'hFF; enable_pc = 1'b0; opcode = ADD; pc = '0;
    cycles(2);
    rst = 1'b1;
    cycles(1);
  endtask

  task automatic test_reset();
    rst = 1'b0; lines = 8'hA5; mask = 8'hFF; enable_pc = 1'b1; opcode = ADD; pc = 32'h10;
    cycles(2);
    #1;
    checks++; if (irr !== 1'b0) begin errors++; $display("FAIL rst_irr got %b exp 0", irr); end
    checks++; if (irr_ret !== 32'h0) begin errors++; $display("FAIL rst_ret got %h exp 0", irr_ret); end
    checks++; if (irq_id !== 5'd0) begin errors++; $display("FAIL rst_id got %0d exp 0", irq_id); end
    checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL rst_insvc got %b exp 0", in_service); end
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(); #1;
      checks++; if (irr !== 1'b0) begin errors++; $display("FAIL rel_high_irr cyc %0d got %b exp 0", i, irr); end
      checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL rel_high_insvc cyc %0d got %b exp 0", i, in_service); end
    end
    lines = '0;
    cycles(3);
  endtask

  task automatic test_dispatch();
    do_reset();
    lines[3] = 1'b1;
    cycles(3); #1;
    checks++; if (irr !== 1'b0) begin errors++; $display("FAIL early_irr got %b exp 0", irr); end
    cyc();
    pc = 32'h40; enable_pc = 1'b1; #1;
    checks++; if (irr !== 1'b1) begin errors++; $display("FAIL disp_irr got %b exp 1", irr); end
    checks++; if (irr_dest !== 32'h130) begin errors++; $display("FAIL disp_dest got %h exp 130", irr_dest); end
    cyc();
    enable_pc = 1'b0; #1;
    checks++; if (irr_ret !== 32'h44) begin errors++; $display("FAIL disp_ret got %h exp 44", irr_ret); end
    checks++; if (in_service !== 1'b1) begin errors++; $display("FAIL disp_insvc got %b exp 1", in_service); end
    checks++; if (irq_id !== 5'd3) begin errors++; $display("FAIL disp_id got %0d exp 3", irq_id); end
    checks++; if (irr !== 1'b0) begin errors++; $display("FAIL svc_irr got %b exp 0", irr); end
  endtask

  task automatic test_priority();
    do_reset();
    lines = 8'b0010_0100;
    cycles(4); #1;
    checks++; if (irq_id !== 5'd2) begin errors++; $display("FAIL prio_id got %0d exp 2", irq_id); end
    checks++; if (irr_dest !== 32'h120) begin errors++; $display("FAIL prio_dest got %h exp 120", irr_dest); end
    pc = 32'h200; enable_pc = 1'b1;
    cyc();
    enable_pc = 1'b0; #1;
    checks++; if (in_service !== 1'b1) begin errors++; $display("FAIL prio_insvc got %b exp 1", in_service); end
    opcode = RETIRQ; enable_pc = 1'b1;
    cyc();
    opcode = ADD; enable_pc = 1'b0; #1;
    checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL ret_insvc got %b exp 0", in_service); end
    checks++; if (irr_ret !== 32'h204) begin errors++; $display("FAIL ret_hold got %h exp 204", irr_ret); end
    cyc(); #1;
    checks++; if (irr !== 1'b1) begin errors++; $display("FAIL b2b_irr got %b exp 1", irr); end
    checks++; if (irq_id !== 5'd5) begin errors++; $display("FAIL b2b_id got %0d exp 5", irq_id); end
    checks++; if (irr_dest !== 32'h150) begin errors++; $display("FAIL b2b_dest got %h exp 150", irr_dest); end
  endtask

  task automatic test_unsafe();
    do_reset();
    lines[6] = 1'b1;
    cycles(4);
    opcode = JAL; enable_pc = 1'b1; #1;
    checks++; if (irr !== 1'b0) begin errors++; $display("FAIL jal_irr got %b exp 0", irr); end
    cyc(); opcode = BEQ; #1;
    checks++; if (irr !== 1'b0) begin errors++; $display("FAIL beq_irr got %b exp 0", irr); end
    cyc(); opcode = JALR; #1;
    checks++; if (irr !== 1'b0) begin errors++; $display("FAIL jalr_irr got %b exp 0", irr); end
    cyc(); opcode = RETIRQ; #1;
    checks++; if (irr !== 1'b0) begin errors++; $display("FAIL retirq_irr got %b exp 0", irr); end
    cyc(); opcode = ADD; pc = 32'h80; #1;
    checks++; if (irr !== 1'b1) begin errors++; $display("FAIL add_irr got %b exp 1", irr); end
    cyc(); enable_pc = 1'b0; #1;
    checks++; if (irr_ret !== 32'h84) begin errors++; $display("FAIL add_ret got %h exp 84", irr_ret); end
    checks++; if (irq_id !== 5'd6) begin errors++; $display("FAIL add_id got %0d exp 6", irq_id); end
  endtask

  task automatic test_mask();
    do_reset();
    mask = 8'hFD; enable_pc = 1'b1; lines[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(); #1;
      checks++; if (irr !== 1'b0) begin errors++; $display("FAIL masked_irr cyc %0d got %b exp 0", i, irr); end
    end
    mask = 8'hFF;
    cyc(); #1;
    checks++; if (irr !== 1'b1) begin errors++; $display("FAIL unmask_irr got %b exp 1", irr); end
    cyc(); #1;
    checks++; if (irq_id !== 5'd1) begin errors++; $display("FAIL unmask_id got %0d exp 1", irq_id); end
    checks++; if (in_service !== 1'b1) begin errors++; $display("FAIL unmask_insvc got %b exp 1", in_service); end
    opcode = RETIRQ;
    cyc();
    opcode = ADD; enable_pc = 1'b0; lines[7] = 1'b1;
    cycles(4); #1;
    checks++; if (irr !== 1'b1) begin errors++; $display("FAIL arm7_irr got %b exp 1", irr); end
    mask = 8'h7F; enable_pc = 1'b1; #1;
    checks++; if (irr !== 1'b0) begin errors++; $display("FAIL drop_irr got %b exp 0", irr); end
    cycles(2); #1;
    checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL drop_insvc got %b exp 0", in_service); end
    checks++; if (irr !== 1'b0) begin errors++; $display("FAIL drop_idle_irr got %b exp 0", irr); end
  endtask

  task automatic test_rearm();
    do_reset();
    lines[4] = 1'b1;
    cycles(4);
    enable_pc = 1'b1;
    cyc();
    lines[4] = 1'b0;
    cyc();
    lines[4] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(); #1;
      checks++; if (irr !== 1'b0) begin errors++; $display("FAIL nest_irr cyc %0d got %b exp 0", i, irr); end
    end
    checks++; if (in_service !== 1'b1) begin errors++; $display("FAIL nest_insvc got %b exp 1", in_service); end
    opcode = RETIRQ;
    cyc();
    opcode = ADD; enable_pc = 1'b0; #1;
    checks++; if (irr !== 1'b0) begin errors++; $display("FAIL rearm_idle_irr got %b exp 0", irr); end
    cyc(); #1;
    checks++; if (irr !== 1'b1) begin errors++; $display("FAIL rearm_irr got %b exp 1", irr); end
    checks++; if (irq_id !== 5'd4) begin errors++; $display("FAIL rearm_id got %0d exp 4", irq_id); end
    // New edge on line 4 lands in the same cycle it is accepted.
    lines[4] = 1'b0;
    cyc();
    lines[4] = 1'b1;
    cycles(2);
    enable_pc = 1'b1;
    cyc();
    enable_pc = 1'b0; opcode = RETIRQ; enable_pc = 1'b1;
    cyc();
    opcode = ADD; enable_pc = 1'b0;
    cyc(); #1;
    checks++; if (irr !== 1'b1) begin errors++; $display("FAIL setwins_irr got %b exp 1", irr); end
    checks++; if (irq_id !== 5'd4) begin errors++; $display("FAIL setwins_id got %0d exp 4", irq_id); end
  endtask

  task automatic test_reset_service();
    do_reset();
    lines[2] = 1'b1;
    cycles(4);
    pc = 32'h300; enable_pc = 1'b1;
    cyc();
    enable_pc = 1'b0; lines[6] = 1'b1;
    cycles(4);
    rst = 1'b0;
    cyc(); #1;
    checks++; if (irr !== 1'b0) begin errors++; $display("FAIL rsvc_irr got %b exp 0", irr); end
    checks++; if (irr_ret !== 32'h0) begin errors++; $display("FAIL rsvc_ret got %h exp 0", irr_ret); end
    checks++; if (irq_id !== 5'd0) begin errors++; $display("FAIL rsvc_id got %0d exp 0", irq_id); end
    checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL rsvc_insvc got %b exp 0", in_service); end
    rst = 1'b1; enable_pc = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(); #1;
      checks++; if (irr !== 1'b0) begin errors++; $display("FAIL lost_irr cyc %0d got %b exp 0", i, irr); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      rst       = ($urandom_range(0, 299) != 0);
      lines     = lines ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      mask      = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      enable_pc = 1'($urandom_range(0, 1));
      pc        = {$urandom} & 32'hFFFF_FFFC;
      case ($urandom_range(0, 5))
        0: opcode = JAL;
        1: opcode = BEQ;
        2: opcode = JALR;
        3: opcode = RETIRQ;
        4: opcode = ADD;
        default: opcode = 12'($urandom);
      endcase
      #1;
      checks++; if (irr !== ref_irr()) begin errors++; $display("FAIL rnd_irr n %0d got %b exp %b", n, irr, ref_irr()); end
      checks++; if (in_service !== m_insvc) begin errors++; $display("FAIL rnd_insvc n %0d got %b exp %b", n, in_service, m_insvc); end
      checks++; if (irq_id !== 5'(m_id)) begin errors++; $display("FAIL rnd_id n %0d got %0d exp %0d", n, irq_id, m_id); end
      checks++; if (irr_ret !== m_ret) begin errors++; $display("FAIL rnd_ret n %0d got %h exp %h", n, irr_ret, m_ret); end
      if (m_state != 0) begin
        checks++;
        if (irr_dest !== 32'h100 + 32'(m_id * 16)) begin
          errors++; $display("FAIL rnd_dest n %0d got %h exp %h", n, irr_dest, 32'h100 + 32'(m_id * 16));
        end
      end
      cyc();
    end
  endtask

  initial begin
    rst = 1'b0; lines = '0; mask = 8'hFF; enable_pc = 1'b0; pc = '0; opcode = ADD;
    @(negedge clk);
    test_reset();
    test_dispatch();
    test_priority();
    test_unsafe();
    test_mask();
    test_rearm();
    test_reset_service();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
